// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the PLL-domain reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        LOCK_LOST = 3'd4
    } pll_rst_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        logic [LOSS_CNT_W-1:0] r;
        if (v == {LOSS_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low clear.
module cdc_sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_r;

    // Shift chain clocked in the destination domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release for the PLL-derived domain: waits for stable lock,
// releases stages in order, and restarts after lock loss or a soft request.
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES     = 256
) (
    input  logic                  clk72,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [2:0]            state
);

    localparam int MAX_CYC = max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, HOLDOFF_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STAGES - 1);

    logic                  locked_s;
    pll_rst_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic [NUM_STAGES-1:0] stage_r, stage_nxt_s;
    logic                  ready_r, ready_nxt_s;
    logic [LOSS_CNT_W-1:0] loss_r, loss_nxt_s;
    logic                  rel_on_s;

    cdc_sync_bit #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk72),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state, counter and output decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        ready_nxt_s = ready_r;
        loss_nxt_s  = loss_r;
        rel_on_s    = 1'b0;
        stage_nxt_s = '0;

        case (state_r)
            WAIT_LOCK: begin
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
                ready_nxt_s = 1'b0;
                if (locked_s) begin
                    state_nxt_s = STABILIZE;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = '0;
                    idx_nxt_s   = '0;
                    rel_on_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            RELEASE, RUN: begin
                // A lock drop wins over a coincident soft request so it is counted
                if (!locked_s) begin
                    state_nxt_s = LOCK_LOST;
                    cnt_nxt_s   = '0;
                    ready_nxt_s = 1'b0;
                    loss_nxt_s  = sat_inc(loss_r);
                end else if (soft_rst_req) begin
                    state_nxt_s = LOCK_LOST;
                    cnt_nxt_s   = '0;
                    ready_nxt_s = 1'b0;
                end else if (state_r == RUN) begin
                    rel_on_s = 1'b1;
                end else if (idx_r == LAST_IDX) begin
                    state_nxt_s = RUN;
                    ready_nxt_s = 1'b1;
                    rel_on_s    = 1'b1;
                end else if (cnt_r == GAP_LAST) begin
                    idx_nxt_s = idx_r + IDX_W'(1);
                    cnt_nxt_s = '0;
                    rel_on_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    rel_on_s  = 1'b1;
                end
            end
            LOCK_LOST: begin
                ready_nxt_s = 1'b0;
                if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = WAIT_LOCK;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
                ready_nxt_s = 1'b0;
            end
        endcase

        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_nxt_s[i] = rel_on_s && (IDX_W'(i) <= idx_nxt_s);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk72 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
            idx_r   <= '0;
            stage_r <= '0;
            ready_r <= 1'b0;
            loss_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            stage_r <= stage_nxt_s;
            ready_r <= ready_nxt_s;
            loss_r  <= loss_nxt_s;
        end
    end

    assign stage_rst_n     = stage_r;
    assign ready           = ready_r;
    assign lock_loss_count = loss_r;
    assign state           = state_r;

endmodule
